// File: rtl/combo_lock_pkg.sv
// Shared types and width helpers for the parametrised combination lock.
// The state encodings are also used by the board-level display top.
package combo_lock_pkg;

  typedef enum logic [2:0] {
    StEntry   = 3'd0,
    StOpen    = 3'd1,
    StFail    = 3'd2,
    StLockout = 3'd3,
    StProg    = 3'd4
  } state_e;

  function automatic int unsigned idx_width(input int unsigned code_len);
    return $clog2(code_len + 1);
  endfunction

  function automatic int unsigned cnt_width(input int unsigned max_tries);
    return $clog2(max_tries + 1);
  endfunction

  // Widths for the default 6-digit / 3-try configuration.
  localparam int unsigned IDX_W = idx_width(6);
  localparam int unsigned CNT_W = cnt_width(3);

endpackage

// File: rtl/combo_code_store.sv
// Active code register plus a shadow register filled digit by digit while programming.
// Commit copies the shadow, including a same-cycle write, into the active code.
module combo_code_store import combo_lock_pkg::*; #(
  parameter int unsigned CODE_LEN = 6,
  parameter int unsigned DIGIT_W  = 4,
  parameter logic [CODE_LEN*DIGIT_W-1:0] DEFAULT_CODE = {4'd8, 4'd3, 4'd8, 4'd4, 4'd8, 4'd2}
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [idx_width(CODE_LEN)-1:0]    wr_idx,
  input  logic [DIGIT_W-1:0]                wr_data,
  input  logic                              we,
  input  logic                              commit,
  input  logic [idx_width(CODE_LEN)-1:0]    rd_idx,
  output logic [DIGIT_W-1:0]                rd_data
);

  localparam int unsigned IdxW = idx_width(CODE_LEN);

  logic [CODE_LEN*DIGIT_W-1:0] code_q, code_d;
  logic [CODE_LEN*DIGIT_W-1:0] shadow_q, shadow_d;

  // Digit 0 is the first one entered and lives in the most significant slot.
  always_comb begin
    shadow_d = shadow_q;
    rd_data  = '0;
    for (int i = 0; i < int'(CODE_LEN); i++) begin
      if (we && (wr_idx == IdxW'(i))) begin
        shadow_d[(CODE_LEN-1-i)*DIGIT_W +: DIGIT_W] = wr_data;
      end
      if (rd_idx == IdxW'(i)) begin
        rd_data = code_q[(CODE_LEN-1-i)*DIGIT_W +: DIGIT_W];
      end
    end
    code_d = commit ? shadow_d : code_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      code_q   <= DEFAULT_CODE;
      shadow_q <= DEFAULT_CODE;
    end else begin
      code_q   <= code_d;
      shadow_q <= shadow_d;
    end
  end

endmodule

// File: rtl/combo_lock_param.sv
// Combination-lock controller: digit entry, failure counting with sticky lockout,
// and runtime reprogramming of the code. All outputs are registered.
module combo_lock_param import combo_lock_pkg::*; #(
  parameter int unsigned CODE_LEN  = 6,
  parameter int unsigned DIGIT_W   = 4,
  parameter int unsigned RADIX     = 10,
  parameter int unsigned MAX_TRIES = 3,
  parameter logic [CODE_LEN*DIGIT_W-1:0] DEFAULT_CODE = {4'd8, 4'd3, 4'd8, 4'd4, 4'd8, 4'd2}
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [DIGIT_W-1:0]                 digit_in,
  input  logic                               enter,
  input  logic                               relock,
  input  logic                               program_req,
  output logic [2:0]                         state_code,
  output logic                               unlocked,
  output logic                               locked_out,
  output logic [idx_width(CODE_LEN)-1:0]     digit_idx,
  output logic [cnt_width(MAX_TRIES)-1:0]    fail_count,
  output logic [DIGIT_W-1:0]                 last_digit,
  output logic                               digit_err
);

  localparam int unsigned IdxW = idx_width(CODE_LEN);
  localparam int unsigned CntW = cnt_width(MAX_TRIES);
  localparam logic [DIGIT_W:0]  RadixV   = RADIX[DIGIT_W:0];
  localparam logic [IdxW-1:0]   LastIdx  = IdxW'(CODE_LEN - 1);
  localparam logic [CntW-1:0]   MaxTries = CntW'(MAX_TRIES);

  state_e            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [CntW-1:0]   fail_q, fail_d;
  logic [DIGIT_W-1:0] last_q, last_d;
  logic              err_q, err_d;
  logic              mismatch_q, mismatch_d;
  logic              unlocked_q, locked_q;

  logic              valid;
  logic              mm;
  logic [CntW-1:0]   fail_inc;
  logic [DIGIT_W-1:0] code_digit;
  logic              st_we, st_commit;

  combo_code_store #(
    .CODE_LEN     (CODE_LEN),
    .DIGIT_W      (DIGIT_W),
    .DEFAULT_CODE (DEFAULT_CODE)
  ) u_store (
    .clk     (clk),
    .reset   (reset),
    .wr_idx  (idx_q),
    .wr_data (digit_in),
    .we      (st_we),
    .commit  (st_commit),
    .rd_idx  (idx_q),
    .rd_data (code_digit)
  );

  assign valid    = enter && ({1'b0, digit_in} < RadixV);
  assign mm       = mismatch_q | (digit_in != code_digit);
  assign fail_inc = (fail_q == MaxTries) ? fail_q : fail_q + CntW'(1);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    fail_d     = fail_q;
    last_d     = last_q;
    mismatch_d = mismatch_q;
    err_d      = enter && !valid;
    st_we      = 1'b0;
    st_commit  = 1'b0;

    unique case (state_q)
      StEntry: begin
        if (valid) begin
          last_d = digit_in;
          if (idx_q == LastIdx) begin
            idx_d      = '0;
            mismatch_d = 1'b0;
            if (!mm) begin
              state_d = StOpen;
              fail_d  = '0;
            end else begin
              fail_d  = fail_inc;
              state_d = (fail_inc == MaxTries) ? StLockout : StFail;
            end
          end else begin
            idx_d      = idx_q + IdxW'(1);
            mismatch_d = mm;
          end
        end
      end
      StFail: begin
        // The digit here only acknowledges the failure; it starts no new entry.
        if (valid) begin
          last_d  = digit_in;
          state_d = StEntry;
        end
      end
      StOpen: begin
        if (relock) begin
          state_d = StEntry;
        end else if (program_req) begin
          state_d = StProg;
          idx_d   = '0;
        end
      end
      StProg: begin
        if (relock) begin
          state_d = StEntry;
          idx_d   = '0;
        end else if (valid) begin
          last_d = digit_in;
          st_we  = 1'b1;
          if (idx_q == LastIdx) begin
            st_commit = 1'b1;
            state_d   = StEntry;
            idx_d     = '0;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end
      end
      StLockout: ;
      default: state_d = StEntry;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StEntry;
      idx_q      <= '0;
      fail_q     <= '0;
      last_q     <= '0;
      err_q      <= 1'b0;
      mismatch_q <= 1'b0;
      unlocked_q <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      fail_q     <= fail_d;
      last_q     <= last_d;
      err_q      <= err_d;
      mismatch_q <= mismatch_d;
      unlocked_q <= (state_d == StOpen);
      locked_q   <= (state_d == StLockout);
    end
  end

  assign state_code = state_q;
  assign unlocked   = unlocked_q;
  assign locked_out = locked_q;
  assign digit_idx  = idx_q;
  assign fail_count = fail_q;
  assign last_digit = last_q;
  assign digit_err  = err_q;

endmodule
